// File: rtl/nn_mac_pipe.sv
// Multi-lane MAC / multiply-add / clear / ReLU execute engine with a per-lane
// persistent accumulator, a PIPE_DEPTH-cycle pipeline and valid/ready on both sides.
module nn_mac_pipe #(
  parameter int DATA_W     = 32,
  parameter int LANES      = 4,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                      CLK,
  input  logic                      RST_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_op,
  input  logic [LANES*DATA_W-1:0]   in_a,
  input  logic [LANES*DATA_W-1:0]   in_b,
  input  logic [LANES*DATA_W-1:0]   in_c,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      busy,
  output logic [31:0]               op_count
);

  localparam int STAGES = PIPE_DEPTH - 1;
  localparam int LW     = LANES * DATA_W;

  localparam logic [1:0] OP_MAC    = 2'b00;
  localparam logic [1:0] OP_MULADD = 2'b01;
  localparam logic [1:0] OP_CLR    = 2'b10;
  localparam logic [1:0] OP_RELU   = 2'b11;

  logic              stall;
  logic              accept;
  logic              commit;
  logic              st_v   [STAGES];
  logic [1:0]        st_op  [STAGES];
  logic [LW-1:0]     st_p   [STAGES];
  logic [LW-1:0]     st_c   [STAGES];
  logic [DATA_W-1:0] acc    [LANES];
  logic [DATA_W-1:0] acc_nxt[LANES];
  logic [LW-1:0]     prod;
  logic [LW-1:0]     res_nxt;

  // Handshake: a transfer happens on a rising edge where valid && ready; the only
  // thing that blocks the engine is an unconsumed result in the output register.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign commit   = st_v[STAGES-1] && !stall;

  always_comb begin
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      prod[i*DATA_W +: DATA_W] = in_a[i*DATA_W +: DATA_W] * in_b[i*DATA_W +: DATA_W];
    end
  end

  // Accumulators are read only here, so back-to-back MACs see every older commit.
  always_comb begin
    res_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      acc_nxt[i] = acc[i];
      case (st_op[STAGES-1])
        OP_MAC: begin
          acc_nxt[i] = acc[i] + st_p[STAGES-1][i*DATA_W +: DATA_W];
          res_nxt[i*DATA_W +: DATA_W] = acc_nxt[i];
        end
        OP_MULADD: res_nxt[i*DATA_W +: DATA_W] =
          st_p[STAGES-1][i*DATA_W +: DATA_W] + st_c[STAGES-1][i*DATA_W +: DATA_W];
        OP_CLR: begin
          acc_nxt[i] = '0;
          res_nxt[i*DATA_W +: DATA_W] = '0;
        end
        OP_RELU: res_nxt[i*DATA_W +: DATA_W] = acc[i][DATA_W-1] ? '0 : acc[i];
        default: res_nxt[i*DATA_W +: DATA_W] = '0;
      endcase
    end
  end

  always_comb begin
    busy = out_valid;
    for (int k = 0; k < STAGES; k++) begin
      busy = busy | st_v[k];
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int k = 0; k < STAGES; k++) begin
        st_v[k]  <= 1'b0;
        st_op[k] <= '0;
        st_p[k]  <= '0;
        st_c[k]  <= '0;
      end
    end else if (!stall) begin
      st_v[0] <= accept;
      if (accept) begin
        st_op[0] <= in_op;
        st_p[0]  <= prod;
        st_c[0]  <= in_c;
      end
      for (int k = 1; k < STAGES; k++) begin
        st_v[k]  <= st_v[k-1];
        st_op[k] <= st_op[k-1];
        st_p[k]  <= st_p[k-1];
        st_c[k]  <= st_c[k-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      op_count  <= '0;
      for (int i = 0; i < LANES; i++) begin
        acc[i] <= '0;
      end
    end else begin
      if (out_valid && out_ready) begin
        op_count <= op_count + 32'd1;
      end
      if (!stall) begin
        out_valid <= st_v[STAGES-1];
      end
      if (commit) begin
        out_data <= res_nxt;
        for (int i = 0; i < LANES; i++) begin
          acc[i] <= acc_nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_nn_mac_pipe.sv
// Scoreboard bench for nn_mac_pipe: a lane-level reference model queues expected
// results at accept time; a negedge monitor checks data, latency, stalls and op_count.
module tb_nn_mac_pipe;

  localparam int W  = 32;
  localparam int L  = 4;
  localparam int PD = 3;
  localparam int LW = W * L;

  logic          CLK = 1'b0;
  logic          RST_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [LW-1:0] in_a, in_b, in_c;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_data;
  logic          busy;
  logic [31:0]   op_count;

  nn_mac_pipe #(.DATA_W(W), .LANES(L), .PIPE_DEPTH(PD)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .op_count(op_count)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] out_log[$];
  int lat_acc_q[$];
  int lat_stall_q[$];
  logic [W-1:0] m_acc[L];
  int cyc = 0;
  int stall_cnt = 0;
  int hs_cnt = 0;
  bit last_acc = 0;
  bit prev_hold = 0;
  logic [LW-1:0] prev_data;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Commit order equals accept order, so applying the op rules at accept time is exact.
  function automatic logic [LW-1:0] model_op(input logic [1:0] op,
                                             input logic [LW-1:0] a, b, c);
    logic [LW-1:0] r;
    r = '0;
    for (int i = 0; i < L; i++) begin
      logic [W-1:0] p;
      p = a[i*W +: W] * b[i*W +: W];
      case (op)
        2'b00: begin m_acc[i] = m_acc[i] + p; r[i*W +: W] = m_acc[i]; end
        2'b01: r[i*W +: W] = p + c[i*W +: W];
        2'b10: begin m_acc[i] = '0; r[i*W +: W] = '0; end
        default: r[i*W +: W] = ($signed(m_acc[i]) < 0) ? '0 : m_acc[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge CLK) begin
    cyc++;
    last_acc = 0;
    if (RST_n && in_valid && in_ready) begin
      last_acc = 1;
      exp_q.push_back(model_op(in_op, in_a, in_b, in_c));
      lat_acc_q.push_back(cyc);
      lat_stall_q.push_back(stall_cnt);
    end
  end

  always @(negedge CLK) begin
    if (!RST_n) begin
      prev_hold = 0;
      hs_cnt = 0;
    end else begin
      chk("in_ready", LW'(in_ready), LW'(!(out_valid && !out_ready)));
      chk("op_count", LW'(op_count), LW'(hs_cnt));
      if (prev_hold) begin
        chk("hold_valid", LW'(out_valid), LW'(1));
        chk("hold_data", out_data, prev_data);
      end else if (out_valid) begin
        if (lat_acc_q.size() == 0) begin
          chk("spurious_out", LW'(out_valid), LW'(0));
        end else begin
          int ea, es;
          ea = lat_acc_q.pop_front();
          es = lat_stall_q.pop_front();
          chk("latency", LW'(cyc), LW'(ea + PD - 1 + (stall_cnt - es)));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", LW'(1), LW'(0));
        else chk("out_data", out_data, exp_q.pop_front());
        out_log.push_back(out_data);
        hs_cnt++;
      end
      if (out_valid && !out_ready) stall_cnt++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic flush_model();
    exp_q.delete();
    lat_acc_q.delete();
    lat_stall_q.delete();
    for (int i = 0; i < L; i++) m_acc[i] = '0;
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, b, c);
    int n;
    in_valid = 1; in_op = op;
    in_a = {L{a}}; in_b = {L{b}}; in_c = {L{c}};
    n = 0;
    @(negedge CLK);
    while (!in_ready && n < 1000) begin @(negedge CLK); n++; end
    if (n >= 1000) chk("send_timeout", LW'(in_ready), LW'(1));
    @(posedge CLK); #1;
    in_valid = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin @(negedge CLK); n++; end
    chk("drain_done", LW'(exp_q.size()), LW'(0));
    @(posedge CLK); #1;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [W-1:0] v);
    if (idx >= out_log.size()) chk({name, "_missing"}, LW'(out_log.size()), LW'(idx + 1));
    else chk(name, out_log[idx], {L{v}});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, guard;
    bit pending;
    logic [W-1:0] neg7, negone;
    neg7 = -32'sd7;
    negone = -32'sd1;
    RST_n = 0; in_valid = 0; in_op = 0; in_a = '0; in_b = '0; in_c = '0; out_ready = 1;
    flush_model();
    repeat (3) @(posedge CLK);
    #1 RST_n = 1;

    // T1: reset with ops in flight, then a zero MAC must yield zero.
    send(2'b00, 32'd5, 32'd3, 0);
    send(2'b00, 32'd1, 32'd1, 0);
    send(2'b00, 32'd2, 32'd2, 0);
    #2 RST_n = 0;
    flush_model();
    #1;
    chk("rst_out_valid", LW'(out_valid), LW'(0));
    chk("rst_busy", LW'(busy), LW'(0));
    chk("rst_op_count", LW'(op_count), LW'(0));
    chk("rst_in_ready", LW'(in_ready), LW'(1));
    chk("rst_out_data", out_data, '0);
    repeat (2) @(posedge CLK);
    #1 RST_n = 1;
    out_log.delete();
    send(2'b00, 32'd0, 32'd0, 0);
    wait_drain();
    chk_log("t1_zero_mac", 0, 32'd0);

    // T2: CLR then four back-to-back MACs.
    out_log.delete();
    send(2'b10, 0, 0, 0);
    repeat (4) send(2'b00, 32'd2, 32'd3, 0);
    wait_drain();
    for (int i = 0; i < 5; i++) chk_log("t2_seq", i, 32'(6 * i));
    chk("t2_op_count", LW'(op_count), LW'(6));

    // T3: consumer stalls for 5 cycles while ops stream in.
    out_log.delete();
    fork
      for (int i = 1; i <= 8; i++) send(2'b00, 32'(i), 32'd1, 0);
      begin
        out_ready = 0;
        repeat (5) @(posedge CLK);
        #1 out_ready = 1;
      end
    join
    wait_drain();
    for (int i = 0; i < 8; i++) chk_log("t3_seq", i, 32'(24 + (i + 1) * (i + 2) / 2));

    // T4: ReLU of a negative accumulator and MULADD leave the accumulator alone.
    out_log.delete();
    send(2'b10, 0, 0, 0);
    send(2'b00, neg7, 32'd1, 0);
    send(2'b11, 0, 0, 0);
    send(2'b01, 32'd4, 32'd5, negone);
    send(2'b00, 32'd0, 32'd0, 0);
    wait_drain();
    chk_log("t4_mac", 1, neg7);
    chk_log("t4_relu", 2, 32'd0);
    chk_log("t4_muladd", 3, 32'd19);
    chk_log("t4_acc_kept", 4, neg7);

    // T5: wrap-around of accumulator and product.
    out_log.delete();
    send(2'b10, 0, 0, 0);
    send(2'b00, 32'h7FFF_FFFF, 32'd1, 0);
    send(2'b00, 32'h7FFF_FFFF, 32'd1, 0);
    send(2'b01, 32'h0001_0000, 32'h0001_0000, 0);
    wait_drain();
    chk_log("t5_wrap1", 1, 32'h7FFF_FFFF);
    chk_log("t5_wrap2", 2, 32'hFFFF_FFFE);
    chk_log("t5_prod", 3, 32'd0);

    // T6: random per-lane operands with random valid/ready.
    sent = 0; guard = 0; pending = 0;
    while (sent < 10000 && guard < 60000) begin
      @(posedge CLK); #1;
      guard++;
      if (pending && last_acc) begin pending = 0; sent++; end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && sent < 10000 && $urandom_range(0, 3) != 0) begin
        int r;
        pending = 1;
        r = $urandom_range(0, 15);
        in_op = (r == 0) ? 2'b10 : (r < 3) ? 2'b11 : (r < 6) ? 2'b01 : 2'b00;
        for (int i = 0; i < L; i++) begin
          in_a[i*W +: W] = $urandom();
          in_b[i*W +: W] = ($urandom_range(0, 1) != 0) ? $urandom() : W'($urandom_range(0, 9));
          in_c[i*W +: W] = $urandom();
        end
      end
      in_valid = pending;
    end
    chk("t6_sent", LW'(sent), LW'(10000));
    in_valid = 0;
    out_ready = 1;
    wait_drain();
    chk("end_busy", LW'(busy), LW'(0));
    chk("end_op_count", LW'(op_count), LW'(hs_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
